// File: rtl/ew_pkg.sv
// Shared types for the element-wise stream engine: opcodes, FP unit select,
// the IEEE single constant 1.0 and small opcode helpers.
package ew_pkg;

  typedef enum logic [2:0] {
    OP_ADD      = 3'd0,
    OP_ELE_MUL  = 3'd1,
    OP_SCAL_ADD = 3'd2,
    OP_SCAL_MUL = 3'd3,
    OP_SCAL_DIV = 3'd4,
    OP_SCAL_INV = 3'd5
  } ew_op_t;

  typedef enum logic [1:0] {
    SEL_ADD = 2'd0,
    SEL_MUL = 2'd1,
    SEL_DIV = 2'd2
  } ew_sel_t;

  localparam logic [31:0] FP_ONE = 32'h3F800000;

  // Which external FP unit serves an opcode.
  function automatic ew_sel_t op_to_sel(input logic [2:0] op);
    case (op)
      OP_ELE_MUL, OP_SCAL_MUL:  return SEL_MUL;
      OP_SCAL_DIV, OP_SCAL_INV: return SEL_DIV;
      default:                  return SEL_ADD;
    endcase
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    return op <= 3'd5;
  endfunction

  // Only the two-matrix ops read the B bank.
  function automatic logic op_uses_b(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_ELE_MUL);
  endfunction

endpackage

// File: rtl/ew_stream_engine_valid_pipe.sv
// Valid shift register of parametrised depth with a runtime tap.
// vld_pipe[k] is vld_i delayed by k cycles; vld_o = vld_pipe[tap_i].
module ew_valid_pipe #(
  parameter int DEPTH = 7,
  parameter int TW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          vld_i,
  input  logic [TW-1:0] tap_i,
  output logic          vld_o
);

  logic [DEPTH-1:0] stg_q;
  logic [DEPTH:0]   vld_pipe;

  assign vld_pipe = {stg_q, vld_i};
  assign vld_o    = vld_pipe[tap_i];

  // Shift every stage by one per cycle; reset empties the pipe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) stg_q <= '0;
    else          stg_q <= vld_pipe[DEPTH-1:0];
  end

endmodule

// File: rtl/ew_stream_engine.sv
// Element-wise stream engine: one command streams LANES-wide words from the
// A/B banks through the external FP units back into the result bank, one word
// issued per cycle with reads, compute and writes overlapped.
// Optional macro EW_PERF_CNT_EN adds saturating perf_busy / perf_words counters.
module ew_stream_engine
  import ew_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int LEN_WIDTH  = 12,
  parameter int LAT_ADD    = 7,
  parameter int LAT_MUL    = 5,
  parameter int LAT_DIV    = 6
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [2:0]                  cmd_op,
  input  logic [LEN_WIDTH-1:0]        cmd_len,
  input  logic [DATA_WIDTH-1:0]       cmd_scalar,
  input  logic [ADDR_WIDTH-1:0]       cmd_a_base,
  input  logic [ADDR_WIDTH-1:0]       cmd_b_base,
  input  logic [ADDR_WIDTH-1:0]       cmd_d_base,
  output logic                        rda_en,
  output logic                        rdb_en,
  output logic [ADDR_WIDTH-1:0]       rda_addr,
  output logic [ADDR_WIDTH-1:0]       rdb_addr,
  input  logic [LANES*DATA_WIDTH-1:0] rda_data,
  input  logic [LANES*DATA_WIDTH-1:0] rdb_data,
  output logic                        dp_valid,
  output logic [1:0]                  dp_sel,
  output logic [LANES*DATA_WIDTH-1:0] dp_a,
  output logic [LANES*DATA_WIDTH-1:0] dp_b,
  input  logic [LANES*DATA_WIDTH-1:0] dp_res,
  output logic                        wr_en,
  output logic [ADDR_WIDTH-1:0]       wr_addr,
  output logic [LANES*DATA_WIDTH-1:0] wr_data,
`ifdef EW_PERF_CNT_EN
  output logic [31:0]                 perf_busy,
  output logic [31:0]                 perf_words,
`endif
  output logic                        done,
  output logic                        err
);

  localparam int LAT_MAX = (LAT_ADD > LAT_MUL) ?
                           ((LAT_ADD > LAT_DIV) ? LAT_ADD : LAT_DIV) :
                           ((LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV);
  localparam int LW = $clog2(LAT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE, S_ERR} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              op_q;
  ew_sel_t                 sel_q;
  logic [LEN_WIDTH-1:0]    len_q, i_q, w_q;
  logic [DATA_WIDTH-1:0]   scal_q;
  logic [ADDR_WIDTH-1:0]   a_base_q, b_base_q, d_base_q;
  logic [LW-1:0]           lat_q, lat_d;
  logic                    dpv_q;
  logic                    accept, issue, wr_fire, use_b, is_inv;

  assign cmd_ready = (state_q == S_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign issue     = (state_q == S_ISSUE);
  assign use_b     = op_uses_b(op_q);
  assign is_inv    = (op_q == OP_SCAL_INV);

  // Pipeline latency of the unit selected by the incoming opcode.
  always_comb begin
    lat_d = LW'(LAT_ADD);
    case (op_to_sel(cmd_op))
      SEL_MUL: lat_d = LW'(LAT_MUL);
      SEL_DIV: lat_d = LW'(LAT_DIV);
      default: lat_d = LW'(LAT_ADD);
    endcase
  end

  // Capture the command on accept; held until the next accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= '0;
      sel_q    <= SEL_ADD;
      len_q    <= '0;
      scal_q   <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      d_base_q <= '0;
      lat_q    <= '0;
    end else if (accept) begin
      op_q     <= cmd_op;
      sel_q    <= op_to_sel(cmd_op);
      len_q    <= cmd_len;
      scal_q   <= cmd_scalar;
      a_base_q <= cmd_a_base;
      b_base_q <= cmd_b_base;
      d_base_q <= cmd_d_base;
      lat_q    <= lat_d;
    end
  end

  // Issue / write counters and the one-cycle read-to-operand delay.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      i_q   <= '0;
      w_q   <= '0;
      dpv_q <= 1'b0;
    end else begin
      dpv_q <= issue;
      if (accept) begin
        i_q <= '0;
        w_q <= '0;
      end else begin
        if (issue)   i_q <= i_q + LEN_WIDTH'(1);
        if (wr_fire) w_q <= w_q + LEN_WIDTH'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) begin
        if (!op_legal(cmd_op))        state_d = S_ERR;
        else if (cmd_len == '0)       state_d = S_DONE;
        else                          state_d = S_ISSUE;
      end
      S_ISSUE: if (i_q == len_q - LEN_WIDTH'(1)) state_d = S_DRAIN;
      S_DRAIN: if (w_q == len_q)                  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);
  assign rda_en   = issue;
  assign rdb_en   = issue & use_b;
  assign rda_addr = rda_en ? a_base_q + ADDR_WIDTH'(i_q) : '0;
  assign rdb_addr = rdb_en ? b_base_q + ADDR_WIDTH'(i_q) : '0;
  assign dp_valid = dpv_q;
  assign dp_sel   = (state_q == S_IDLE) ? SEL_ADD : sel_q;

  // Per-lane operand steering; outputs are zero when no operand is valid.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DATA_WIDTH-1:0] a_w, b_w;
    assign a_w = rda_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign b_w = rdb_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign dp_a[g*DATA_WIDTH +: DATA_WIDTH] =
      !dpv_q ? '0 : is_inv ? DATA_WIDTH'(FP_ONE) : a_w;
    assign dp_b[g*DATA_WIDTH +: DATA_WIDTH] =
      !dpv_q ? '0 : use_b ? b_w : is_inv ? a_w : scal_q;
  end

  ew_valid_pipe #(.DEPTH(LAT_MAX), .TW(LW)) u_vpipe (
    .clock   (clock),
    .reset_n (reset_n),
    .vld_i   (dpv_q),
    .tap_i   (lat_q),
    .vld_o   (wr_fire)
  );

  assign wr_en   = wr_fire;
  assign wr_addr = wr_fire ? d_base_q + ADDR_WIDTH'(w_q) : '0;
  assign wr_data = wr_fire ? dp_res : '0;

`ifdef EW_PERF_CNT_EN
  logic [31:0] perf_busy_q, perf_words_q;

  // Saturating activity counters, cleared only by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_busy_q  <= '0;
      perf_words_q <= '0;
    end else begin
      if (state_q != S_IDLE && perf_busy_q != '1) perf_busy_q  <= perf_busy_q + 32'd1;
      if (wr_fire && perf_words_q != '1)          perf_words_q <= perf_words_q + 32'd1;
    end
  end

  assign perf_busy  = perf_busy_q;
  assign perf_words = perf_words_q;
`endif

endmodule
